// File: rtl/ransac_fixed_pkg.sv
// Signed Q16.16 fixed-point type shared by the RANSAC distance pipeline,
// plus the saturating magnitude used for inlier classification.
package ransac_fixed;

  localparam int FIXED_BITS = 32;

  typedef logic signed [FIXED_BITS-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = {1'b0, {(FIXED_BITS-1){1'b1}}};
  localparam fixed_t FIXED_MIN = {1'b1, {(FIXED_BITS-1){1'b0}}};

  // The most-negative code has no positive twin, so it clamps to FIXED_MAX.
  function automatic fixed_t fixed_abs_sat(input fixed_t d);
    fixed_t r;
    r = d;
    if (d[FIXED_BITS-1]) begin
      r = (d == FIXED_MIN) ? FIXED_MAX : -d;
    end
    return r;
  endfunction

endpackage

// File: rtl/fast_inlier_accumulator_fifo.sv
// Generic synchronous result FIFO; head reads zero while empty.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module fast_result_fifo #(
  parameter type data_t = logic [7:0],
  parameter int  depth  = 4
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  push,
  input  data_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output data_t head
);

  localparam int AW = $clog2(depth);

  data_t        mem_q [depth];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         pop_en;
  logic         push_en;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = empty ? data_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fast_inlier_accumulator.sv
// Counts inliers and points per candidate plane from a no-stall distance stream
// and queues one result per set into a small FIFO drained by valid/ready.
module fast_inlier_accumulator
  import ransac_fixed::*;
#(
  parameter int count_bits        = 32,
  parameter int plane_id_bits     = 8,
  parameter int result_fifo_depth = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  fixed_t                   threshold,
  input  logic                     distance_valid,
  input  fixed_t                   distance,
  input  logic [plane_id_bits-1:0] distance_plane_id,
  input  logic                     distance_last,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [plane_id_bits-1:0] result_plane_id,
  output logic [count_bits-1:0]    result_inliers,
  output logic [count_bits-1:0]    result_points,
  output logic                     busy,
  output logic                     overflow,
  output logic                     protocol_error
);

  typedef struct packed {
    logic [plane_id_bits-1:0] plane_id;
    logic [count_bits-1:0]    inliers;
    logic [count_bits-1:0]    points;
  } inlier_result_t;

  logic [count_bits-1:0]    points_acc_q, points_acc_d, points_inc;
  logic [count_bits-1:0]    inliers_acc_q, inliers_acc_d, inliers_inc;
  logic [plane_id_bits-1:0] set_id_q, set_id_d, beat_id;
  logic                     busy_q, busy_d;
  logic                     overflow_q, overflow_d;
  logic                     perr_q, perr_d;
  logic                     is_inlier;
  logic                     push, pop, fifo_full, fifo_empty;
  inlier_result_t           push_data, head;

  always_comb begin
    is_inlier   = (fixed_abs_sat(distance) <= threshold);
    points_inc  = (&points_acc_q) ? points_acc_q : points_acc_q + 1'b1;
    inliers_inc = (is_inlier && !(&inliers_acc_q)) ? inliers_acc_q + 1'b1 : inliers_acc_q;
    beat_id     = busy_q ? set_id_q : distance_plane_id;

    points_acc_d       = points_acc_q;
    inliers_acc_d      = inliers_acc_q;
    set_id_d           = set_id_q;
    busy_d             = busy_q;
    overflow_d         = overflow_q;
    perr_d             = perr_q;
    push               = 1'b0;
    push_data.plane_id = beat_id;
    push_data.inliers  = inliers_inc;
    push_data.points   = points_inc;

    if (distance_valid) begin
      // A mismatched tag is flagged but the beat still counts toward the open set.
      if (busy_q && (distance_plane_id != set_id_q)) perr_d = 1'b1;
      if (distance_last) begin
        push          = 1'b1;
        points_acc_d  = '0;
        inliers_acc_d = '0;
        busy_d        = 1'b0;
        if (fifo_full && !pop) overflow_d = 1'b1;
      end else begin
        points_acc_d  = points_inc;
        inliers_acc_d = inliers_inc;
        set_id_d      = beat_id;
        busy_d        = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      points_acc_q  <= '0;
      inliers_acc_q <= '0;
      set_id_q      <= '0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      perr_q        <= 1'b0;
    end else begin
      points_acc_q  <= points_acc_d;
      inliers_acc_q <= inliers_acc_d;
      set_id_q      <= set_id_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      perr_q        <= perr_d;
    end
  end

  assign pop = !fifo_empty && result_ready;

  fast_result_fifo #(
    .data_t (inlier_result_t),
    .depth  (result_fifo_depth)
  ) u_result_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign result_valid    = !fifo_empty;
  assign result_plane_id = head.plane_id;
  assign result_inliers  = head.inliers;
  assign result_points   = head.points;
  assign busy            = busy_q;
  assign overflow        = overflow_q;
  assign protocol_error  = perr_q;

endmodule

// File: tb/tb_fast_inlier_accumulator.sv
// Scoreboard bench: a reference model queues expected results as beats are driven
// and each DUT pop is compared against the queue head.
module tb_fast_inlier_accumulator;
  import ransac_fixed::*;

  localparam int DEPTH = 4;
  localparam fixed_t ONE = 32'sh0001_0000;

  logic        clock, reset_n;
  fixed_t      threshold, distance;
  logic        distance_valid, distance_last;
  logic [7:0]  distance_plane_id;
  logic        result_valid, result_ready;
  logic [7:0]  result_plane_id;
  logic [31:0] result_inliers, result_points;
  logic        busy, overflow, protocol_error;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] inl;
    logic [31:0] pts;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        m_busy, m_ovf, m_perr;
  logic [7:0]  m_id;
  logic [31:0] m_pts, m_inl;

  fast_inlier_accumulator #(
    .count_bits(32), .plane_id_bits(8), .result_fifo_depth(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .threshold(threshold),
    .distance_valid(distance_valid), .distance(distance),
    .distance_plane_id(distance_plane_id), .distance_last(distance_last),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_plane_id(result_plane_id), .result_inliers(result_inliers),
    .result_points(result_points), .busy(busy), .overflow(overflow),
    .protocol_error(protocol_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic longint mag(input fixed_t d);
    longint v;
    v = longint'(d);
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v;
  endfunction

  task automatic model_clear();
    sb_q.delete();
    m_busy = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    m_id = '0; m_pts = '0; m_inl = '0;
  endtask

  // Called just after a falling edge with inputs for the coming rising edge applied.
  task automatic step();
    exp_t        e;
    logic        inl;
    logic [7:0]  id;
    check_eq("result_valid", result_valid, sb_q.size() != 0);
    check_eq("busy", busy, m_busy);
    check_eq("overflow", overflow, m_ovf);
    check_eq("protocol_error", protocol_error, m_perr);
    if (result_valid && result_ready && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("result_plane_id", result_plane_id, e.id);
      check_eq("result_inliers", result_inliers, e.inl);
      check_eq("result_points", result_points, e.pts);
    end
    if (distance_valid) begin
      inl = (mag(distance) <= longint'(threshold));
      id  = m_busy ? m_id : distance_plane_id;
      if (m_busy && distance_plane_id != m_id) m_perr = 1'b1;
      if (distance_last) begin
        if (sb_q.size() == DEPTH) m_ovf = 1'b1;
        else sb_q.push_back('{id: id, inl: m_inl + 32'(inl), pts: m_pts + 1});
        m_busy = 1'b0; m_pts = '0; m_inl = '0;
      end else begin
        m_pts = m_pts + 1; m_inl = m_inl + 32'(inl);
        m_id = id; m_busy = 1'b1;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic beat(input fixed_t d, input logic [7:0] id, input logic last);
    distance_valid    = 1'b1;
    distance          = d;
    distance_plane_id = id;
    distance_last     = last;
    step();
    distance_valid = 1'b0;
    distance_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset_n = 1'b0; threshold = ONE; result_ready = 1'b1;
    distance_valid = 1'b0; distance = '0; distance_plane_id = '0; distance_last = 1'b0;
    model_clear();
    #2;
    check_eq("rst_result_valid", result_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_protocol_error", protocol_error, 1'b0);
    check_eq("rst_result_points", result_points, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Five-beat set against threshold 1.0: expect {3, 3, 5}.
    beat(32'sh0000_8000, 8'd3, 1'b0);
    beat(-32'sh0000_8000, 8'd3, 1'b0);
    beat(ONE, 8'd3, 1'b0);
    beat(-32'sh0001_8000, 8'd3, 1'b0);
    beat(32'sh0002_0000, 8'd3, 1'b1);
    idle(2);

    threshold = 32'sh0000_8000;
    beat(-32'sh0000_4000, 8'd7, 1'b1);
    idle(2);

    // Most-negative code saturates to FIXED_MAX.
    threshold = FIXED_MAX;
    beat(FIXED_MIN, 8'd9, 1'b1);
    idle(1);
    threshold = FIXED_MAX - 1;
    beat(FIXED_MIN, 8'd10, 1'b1);
    idle(2);

    // Fill the FIFO, then push while popping: nothing may be dropped.
    threshold = ONE;
    result_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) beat(32'sh0, 8'(20 + i), 1'b1);
    idle(1);
    result_ready = 1'b1;
    beat(32'sh0, 8'd30, 1'b1);
    idle(6);

    // Five pushes into a stalled FIFO: the fifth is dropped.
    result_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(32'sh0, 8'(i), 1'b1);
    idle(2);
    check_eq("overflow_after_drop", overflow, 1'b1);
    result_ready = 1'b1;
    idle(6);

    // Reset mid-set discards the partial set and the sticky flag.
    beat(32'sh0, 8'd1, 1'b0);
    beat(32'sh0, 8'd1, 1'b0);
    beat(32'sh0, 8'd1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_overflow", overflow, 1'b0);
    check_eq("midrst_result_valid", result_valid, 1'b0);
    check_eq("midrst_result_inliers", result_inliers, 32'd0);
    model_clear();
    @(negedge clock);
    reset_n = 1'b1;
    beat(32'sh0002_0000, 8'd2, 1'b0);
    beat(32'sh0, 8'd2, 1'b1);
    idle(2);

    // Tag changes 5 -> 6 mid-set: flagged, result keeps tag 5.
    beat(32'sh0, 8'd5, 1'b0);
    beat(32'sh0, 8'd6, 1'b0);
    beat(32'sh0, 8'd6, 1'b1);
    idle(2);
    check_eq("protocol_error_sticky", protocol_error, 1'b1);
    check_eq("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fast_inlier_accumulator.md
Name: fast_inlier_accumulator

Overview:
- Receiving end of the fixed-latency distance pipeline that `fast_vector_dot_product` feeds. It accepts one signed point-to-plane distance per cycle, with no stall possible upstream.
- Classifies each distance as inlier or outlier against a threshold and counts inliers and points per candidate plane.
- On the last point of a set, it queues a per-plane result into a small FIFO. The FIFO drains over a valid/ready handshake toward the RANSAC model-selection logic.

Parameters:
- count_bits, 32: width of the inlier and point counters.
- plane_id_bits, 8: width of the candidate-plane tag carried through the pipeline.
- result_fifo_depth, 4: number of buffered results; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- threshold  in  ransac_fixed::fixed_t  inlier bound; non-negative; stable while busy=1.
- distance_valid  in  1  distance beat present this cycle; no backpressure.
- distance  in  ransac_fixed::fixed_t  signed distance from the pipeline.
- distance_plane_id  in  plane_id_bits  plane tag of this beat.
- distance_last  in  1  final point of the current plane's set.
- result_valid  out  1  FIFO head valid.
- result_ready  in  1  consumer accepts head.
- result_plane_id  out  plane_id_bits  head plane tag.
- result_inliers  out  count_bits  head inlier count.
- result_points  out  count_bits  head point count.
- busy  out  1  a set is partially accumulated.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.
- protocol_error  out  1  sticky: plane tag changed mid-set.

Behaviour:
- Reset, asynchronous, on reset_n low:
  - result_valid, busy, overflow, protocol_error = 0.
  - Accumulators and FIFO pointers = 0; result data outputs = 0.
  - A partial set in progress is discarded; no result is emitted for it.
- Classification (combinational on the input beat):
  - |d| = d when d >= 0, else -d.
  - The most-negative code saturates to the maximum positive value.
  - inlier = (|d| <= threshold), signed compare.
- Accumulation, on each cycle with distance_valid=1:
  - points_acc += 1; inliers_acc += inlier.
  - Both counters saturate at all-ones and never wrap.
- First beat of a set (busy=0):
  - Capture distance_plane_id into set_id.
  - Set busy=1, unless the same beat also has distance_last.
- Mid-set beat (busy=1) with distance_plane_id != set_id:
  - Set protocol_error.
  - Keep counting under set_id.
- Beat with distance_last=1:
  - Push {set_id (or current id for a single-beat set), inliers_acc+inlier, points_acc+1}.
  - Clear accumulators; busy=0 next cycle.
  - Back-to-back sets are legal: the next cycle's beat starts a new set.
- Result latency: pushed result appears at the FIFO head with result_valid=1 on the cycle after the last beat, if the FIFO was empty.
- FIFO:
  - Pop when result_valid && result_ready.
  - Push when full and no pop in the same cycle: result dropped, overflow set, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both happen, no drop.
  - Pop when empty: ignored.
- Output data holds stable while result_valid=1 && result_ready=0.
- Sticky flags clear only on reset.

Decomposition:
- ransac_fixed package additions:
  - typedef inlier_result_t struct {plane_id, inliers, points}, parameterised through a localparam in this module.
  - function fixed_abs_sat(fixed_t) returning the saturated magnitude.
- Sub-module fast_result_fifo:
  - Generic synchronous FIFO with a type parameter, depth parameter and async active-low reset.
  - Ports: push, pop, full, empty, head.
  - Registered head; same-cycle push-when-full-with-pop supported.

Test Plan:
- threshold=1.0; set of 5 beats, id=3, distances {0.5, -0.5, 1.0, -1.5, 2.0}, last on the 5th beat → one cycle later result_valid=1, plane_id=3, inliers=3, points=5; busy=0.
- Single-beat set, id=7, distance=-0.25, last=1, threshold=0.5 → result {7, 1, 1}.
- distance = most-negative code, threshold = max positive → counted as inlier; with threshold = max-1 → not an inlier.
- result_ready=0; push 5 single-beat sets (ids 0..4) with depth 4 → ids 0..3 retained in order, overflow=1; raise ready → 4 results drained in order, then result_valid=0.
- FIFO full, ready=1; a last beat arrives in the same cycle as a pop → no drop, overflow stays 0, new result is last in order.
- Assert reset_n low asynchronously mid-set after 3 beats → outputs zero immediately; next 2-beat set reports points=2 (partial set not carried over). Separately, a mid-set id change 5→6 → protocol_error=1 and result plane_id=5.
